// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial a - b - bin, LSB-first, with start/busy/done handshake
// Result and flags change only when the last digit completes; partial results stay internal.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  a_sh, b_sh, res_sh, res_next;
  logic              brw, sm_l, a_msb, b_msb;
  logic [CW-1:0]     cnt;
  logic              last;
  logic [DIGIT:0]    dig_sum;

  assign last     = (cnt == CW'(N - 1));
  // Top bit of the (DIGIT+1)-bit difference is the borrow out of this digit.
  assign dig_sum  = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw};
  assign res_next = (res_sh >> DIGIT) | (WIDTH'(dig_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      brw    <= 1'b0;
      sm_l   <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          a_sh   <= a;
          b_sh   <= b;
          brw    <= bin;
          sm_l   <= signed_mode;
          a_msb  <= a[WIDTH-1];
          b_msb  <= b[WIDTH-1];
          res_sh <= '0;
          cnt    <= '0;
        end
        ST_RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          brw    <= dig_sum[DIGIT];
          res_sh <= res_next;
          cnt    <= cnt + CW'(1);
          if (last) begin
            diff <= res_next;
            bout <= dig_sum[DIGIT];
            // Borrow into the MSB is recovered as a^b^diff at that bit position.
            ovf  <= sm_l ? (a_msb ^ b_msb ^ res_next[WIDTH-1] ^ dig_sum[DIGIT])
                         : dig_sum[DIGIT];
            zero <= (res_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
